// File: rtl/frame_stream_pkg.sv
// Shared types and width helpers for the frame stream engine and its buffers.
package frame_stream_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_LOADED = 2'd1;
  localparam state_t ST_STREAM = 2'd2;
  localparam state_t ST_DRAIN  = 2'd3;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } pix_flags_t;

  function automatic int width_of(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  function automatic int addr_width(input int width, input int height);
    return width_of(width * height);
  endfunction

  function automatic int coord_width(input int extent);
    return width_of(extent);
  endfunction

endpackage

// File: rtl/frame_stream_engine_frame_ram.sv
// Single-write-port frame buffer with a registered read port; a same-cycle
// write to the read address returns the old contents.
module frame_ram
  import frame_stream_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = width_of(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Storage is never reset; only the read register is, so the port reads 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/frame_stream_engine.sv
// Frame source/sink: buffers one frame, replays it as a tagged raster stream,
// and captures the filter's per-pixel results and centroid.
module frame_stream_engine
  import frame_stream_pkg::*;
#(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256,
  parameter int DEPTH      = 8,
  parameter int CHANNELS   = 3,
  parameter int RES_W      = 8,
  localparam int N  = IMG_WIDTH * IMG_HEIGHT,
  localparam int AW = addr_width(IMG_WIDTH, IMG_HEIGHT),
  localparam int XW = coord_width(IMG_WIDTH),
  localparam int YW = coord_width(IMG_HEIGHT),
  localparam int PW = CHANNELS * DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [PW-1:0] load_data,
  input  logic          start,
  input  logic          repeat_en,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [PW-1:0] pix_data,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          pix_sof,
  output logic          pix_eol,
  output logic          pix_eof,
  input  logic          res_valid,
  input  logic [RES_W-1:0] res_data,
  input  logic          cent_valid,
  input  logic [XW-1:0] cent_x,
  input  logic [YW-1:0] cent_y,
  output logic          frame_cent_valid,
  output logic [XW-1:0] frame_cent_x,
  output logic [YW-1:0] frame_cent_y,
  input  logic [AW-1:0] mask_rd_addr,
  output logic [RES_W-1:0] mask_rd_data,
  output logic          busy,
  output logic          frame_done,
  output logic          res_overflow,
  output logic [15:0]   frame_count
);

  localparam logic [AW:0] NUM_PIX = (AW+1)'(N);

  state_t state_q, state_d;
  logic [AW-1:0] load_cnt_q, load_cnt_d;
  logic          load_ready_q, load_ready_d;
  logic [AW:0]   fetch_idx_q, fetch_idx_d;
  logic [XW-1:0] fetch_x_q, fetch_x_d, pend_x_q, pend_x_d, out_x_q, out_x_d, skid_x_q, skid_x_d;
  logic [YW-1:0] fetch_y_q, fetch_y_d, pend_y_q, pend_y_d, out_y_q, out_y_d, skid_y_q, skid_y_d;
  logic          pend_valid_q, pend_valid_d, out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [PW-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
  logic [AW:0]   res_cnt_q, res_cnt_d;
  logic          res_ovf_q, res_ovf_d, cent_valid_q, cent_valid_d;
  logic [XW-1:0] cent_x_q, cent_x_d;
  logic [YW-1:0] cent_y_q, cent_y_d;
  logic [15:0]   frame_count_q, frame_count_d;

  logic          go, issue, pop, accept, pix_we, mask_we, frame_done_c;
  logic [1:0]    occ;
  logic [AW-1:0] rd_addr;
  logic [XW-1:0] base_x;
  logic [YW-1:0] base_y;
  logic [PW-1:0] ram_rdata;
  pix_flags_t    flags;

  always_comb begin
    flags.sof = out_valid_q && (out_x_q == '0) && (out_y_q == '0);
    flags.eol = out_valid_q && (out_x_q == XW'(IMG_WIDTH-1));
    flags.eof = flags.eol && (out_y_q == YW'(IMG_HEIGHT-1));
  end

  always_comb begin
    state_d       = state_q;
    load_cnt_d    = load_cnt_q;
    fetch_idx_d   = fetch_idx_q;
    fetch_x_d     = fetch_x_q;
    fetch_y_d     = fetch_y_q;
    pend_valid_d  = 1'b0;
    pend_x_d      = pend_x_q;
    pend_y_d      = pend_y_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_x_d       = out_x_q;
    out_y_d       = out_y_q;
    skid_valid_d  = skid_valid_q;
    skid_data_d   = skid_data_q;
    skid_x_d      = skid_x_q;
    skid_y_d      = skid_y_q;
    res_cnt_d     = res_cnt_q;
    res_ovf_d     = res_ovf_q;
    cent_valid_d  = cent_valid_q;
    cent_x_d      = cent_x_q;
    cent_y_d      = cent_y_q;
    frame_count_d = frame_count_q;
    go            = 1'b0;
    issue         = 1'b0;
    pix_we        = 1'b0;
    mask_we       = 1'b0;
    rd_addr       = fetch_idx_q[AW-1:0];
    base_x        = fetch_x_q;
    base_y        = fetch_y_q;
    pop           = out_valid_q & pix_ready;
    occ           = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, pend_valid_q};
    accept        = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
    frame_done_c  = (state_q == ST_DRAIN) && (res_cnt_q == NUM_PIX) && cent_valid_q;

    // Read data lands in the output register, or in the skid register while stalled.
    if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_x_d      = skid_x_q;
        out_y_d      = skid_y_q;
        skid_valid_d = pend_valid_q;
        skid_data_d  = ram_rdata;
        skid_x_d     = pend_x_q;
        skid_y_d     = pend_y_q;
      end else if (pend_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = ram_rdata;
        out_x_d     = pend_x_q;
        out_y_d     = pend_y_q;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (pend_valid_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = ram_rdata;
      skid_x_d     = pend_x_q;
      skid_y_d     = pend_y_q;
    end

    if (accept && res_valid) begin
      if (res_cnt_q == NUM_PIX) begin
        res_ovf_d = 1'b1;
      end else begin
        mask_we   = 1'b1;
        res_cnt_d = res_cnt_q + (AW+1)'(1);
      end
    end

    if (accept && cent_valid && !cent_valid_q) begin
      cent_valid_d = 1'b1;
      cent_x_d     = cent_x;
      cent_y_d     = cent_y;
    end

    case (state_q)
      ST_IDLE: begin
        if (load_valid && load_ready_q) begin
          pix_we = 1'b1;
          if (load_cnt_q == AW'(N-1)) begin
            load_cnt_d = '0;
            state_d    = ST_LOADED;
          end else begin
            load_cnt_d = load_cnt_q + AW'(1);
          end
        end
      end
      ST_LOADED: begin
        if (start) begin
          go        = 1'b1;
          res_ovf_d = 1'b0;
          state_d   = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (pop && flags.eof) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (frame_done_c) begin
          frame_count_d = frame_count_q + 16'd1;
          if (repeat_en) begin
            go      = 1'b1;
            state_d = ST_STREAM;
          end else begin
            state_d = ST_LOADED;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reads are issued only when the two holding registers can absorb them.
    if (go) begin
      res_cnt_d    = '0;
      cent_valid_d = 1'b0;
      issue        = 1'b1;
      rd_addr      = '0;
      base_x       = '0;
      base_y       = '0;
    end else if ((state_q == ST_STREAM) && (fetch_idx_q != NUM_PIX) && ((occ - {1'b0, pop}) < 2'd2)) begin
      issue = 1'b1;
    end

    if (issue) begin
      pend_valid_d = 1'b1;
      pend_x_d     = base_x;
      pend_y_d     = base_y;
      fetch_idx_d  = {1'b0, rd_addr} + (AW+1)'(1);
      if (base_x == XW'(IMG_WIDTH-1)) begin
        fetch_x_d = '0;
        fetch_y_d = base_y + YW'(1);
      end else begin
        fetch_x_d = base_x + XW'(1);
        fetch_y_d = base_y;
      end
    end

    if (clear) begin
      state_d       = ST_IDLE;
      load_cnt_d    = '0;
      fetch_idx_d   = '0;
      pend_valid_d  = 1'b0;
      out_valid_d   = 1'b0;
      skid_valid_d  = 1'b0;
      res_cnt_d     = '0;
      res_ovf_d     = 1'b0;
      cent_valid_d  = 1'b0;
      frame_count_d = frame_count_q;
      pix_we        = 1'b0;
      mask_we       = 1'b0;
    end

    load_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      load_cnt_q    <= '0;
      load_ready_q  <= 1'b0;
      fetch_idx_q   <= '0;
      fetch_x_q     <= '0;
      fetch_y_q     <= '0;
      pend_valid_q  <= 1'b0;
      pend_x_q      <= '0;
      pend_y_q      <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_x_q       <= '0;
      out_y_q       <= '0;
      skid_valid_q  <= 1'b0;
      skid_data_q   <= '0;
      skid_x_q      <= '0;
      skid_y_q      <= '0;
      res_cnt_q     <= '0;
      res_ovf_q     <= 1'b0;
      cent_valid_q  <= 1'b0;
      cent_x_q      <= '0;
      cent_y_q      <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      load_cnt_q    <= load_cnt_d;
      load_ready_q  <= load_ready_d;
      fetch_idx_q   <= fetch_idx_d;
      fetch_x_q     <= fetch_x_d;
      fetch_y_q     <= fetch_y_d;
      pend_valid_q  <= pend_valid_d;
      pend_x_q      <= pend_x_d;
      pend_y_q      <= pend_y_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_x_q       <= out_x_d;
      out_y_q       <= out_y_d;
      skid_valid_q  <= skid_valid_d;
      skid_data_q   <= skid_data_d;
      skid_x_q      <= skid_x_d;
      skid_y_q      <= skid_y_d;
      res_cnt_q     <= res_cnt_d;
      res_ovf_q     <= res_ovf_d;
      cent_valid_q  <= cent_valid_d;
      cent_x_q      <= cent_x_d;
      cent_y_q      <= cent_y_d;
      frame_count_q <= frame_count_d;
    end
  end

  frame_ram #(.DEPTH(N), .WIDTH(PW)) u_pix_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (pix_we),
    .wr_addr (load_cnt_q),
    .wr_data (load_data),
    .rd_addr (rd_addr),
    .rd_data (ram_rdata)
  );

  frame_ram #(.DEPTH(N), .WIDTH(RES_W)) u_mask_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (mask_we),
    .wr_addr (res_cnt_q[AW-1:0]),
    .wr_data (res_data),
    .rd_addr (mask_rd_addr),
    .rd_data (mask_rd_data)
  );

  assign load_ready       = load_ready_q;
  assign pix_valid        = out_valid_q;
  assign pix_data         = out_data_q;
  assign pix_x            = out_x_q;
  assign pix_y            = out_y_q;
  assign pix_sof          = flags.sof;
  assign pix_eol          = flags.eol;
  assign pix_eof          = flags.eof;
  assign frame_cent_valid = cent_valid_q;
  assign frame_cent_x     = cent_x_q;
  assign frame_cent_y     = cent_y_q;
  assign busy             = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign frame_done       = frame_done_c & ~clear;
  assign res_overflow     = res_ovf_q;
  assign frame_count      = frame_count_q;

endmodule

// File: tb/tb_frame_stream_engine.sv
// Randomized bench for frame_stream_engine on a 4x4 RGB frame, checked against
// a reference model of the pixel buffer, raster order and mask contents.
module tb_frame_stream_engine;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int XW = 2;
  localparam int YW = 2;
  localparam int AW = 4;
  localparam int PW = 24;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [PW-1:0] load_data = '0;
  logic          start = 1'b0;
  logic          repeat_en = 1'b0;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic [PW-1:0] pix_data;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          pix_sof, pix_eol, pix_eof;
  logic          res_valid = 1'b0;
  logic [RW-1:0] res_data = '0;
  logic          cent_valid = 1'b0;
  logic [XW-1:0] cent_x = '0;
  logic [YW-1:0] cent_y = '0;
  logic          frame_cent_valid;
  logic [XW-1:0] frame_cent_x;
  logic [YW-1:0] frame_cent_y;
  logic [AW-1:0] mask_rd_addr = '0;
  logic [RW-1:0] mask_rd_data;
  logic          busy, frame_done, res_overflow;
  logic [15:0]   frame_count;

  int n_checks = 0;
  int n_pass   = 0;
  int model_frames = 0;
  logic [PW-1:0] model_pix  [N];
  logic [RW-1:0] model_mask [N];
  bit            mask_known [N];

  frame_stream_engine #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .DEPTH(8), .CHANNELS(3), .RES_W(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .start(start), .repeat_en(repeat_en),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .res_valid(res_valid), .res_data(res_data),
    .cent_valid(cent_valid), .cent_x(cent_x), .cent_y(cent_y),
    .frame_cent_valid(frame_cent_valid), .frame_cent_x(frame_cent_x), .frame_cent_y(frame_cent_y),
    .mask_rd_addr(mask_rd_addr), .mask_rd_data(mask_rd_data),
    .busy(busy), .frame_done(frame_done), .res_overflow(res_overflow), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check_all_zero(input string tag);
    logic [63:0] got;
    got = {pix_valid, load_ready, busy, frame_done, res_overflow, frame_cent_valid,
           pix_sof, pix_eol, pix_eof, frame_count, mask_rd_data, pix_data};
    n_checks++;
    if (got !== 64'd0) $display("[TB] FAIL %s: outputs got %h expected 0", tag, got);
    else n_pass++;
  endtask

  task automatic load_frame(input bit patterned);
    int i = 0;
    int guard = 0;
    logic [PW-1:0] data;
    while (i < N && guard < 300) begin
      @(negedge clk);
      guard++;
      data = patterned ? PW'(i * 32'h010101) : PW'($urandom);
      load_valid = ($urandom_range(0, 3) != 0);
      load_data  = data;
      if (load_valid && load_ready) begin
        model_pix[i] = data;
        i++;
      end
    end
    @(negedge clk);
    load_valid = 1'b0;
    n_checks++;
    if (i != N) $display("[TB] FAIL load_timeout: beats got %0d expected %0d", i, N);
    else n_pass++;
    n_checks++;
    if (load_ready !== 1'b0) $display("[TB] FAIL load_ready_after_last: got %b expected 0", load_ready);
    else n_pass++;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({pix_valid, busy, res_overflow, frame_cent_valid} !== 4'b0100)
      $display("[TB] FAIL start_latency: {valid,busy,ovf,cent} got %b expected 0100",
               {pix_valid, busy, res_overflow, frame_cent_valid});
    else n_pass++;
  endtask

  // Streams one frame while feeding results and random mask reads; expects
  // pix_valid on the first sampled cycle and continuously until the last pixel.
  task automatic run_frame(input bit rand_ready, input bit rand_res);
    int k = 0;
    int sent = 0;
    int cycles = 0;
    bit rd_armed = 1'b0;
    logic [RW-1:0] rd_expect = '0;
    logic [AW-1:0] addr;
    logic [PW+XW+YW+2:0] exp_beat, got_beat;
    while ((k < N || sent < N) && cycles < 500) begin
      @(negedge clk);
      cycles++;
      if (rd_armed) begin
        n_checks++;
        if (mask_rd_data !== rd_expect)
          $display("[TB] FAIL mask_read: got %h expected %h", mask_rd_data, rd_expect);
        else n_pass++;
      end
      if (k < N) begin
        n_checks++;
        if (pix_valid !== 1'b1) $display("[TB] FAIL pix_continuous: beat %0d valid got %b expected 1", k, pix_valid);
        else n_pass++;
      end
      pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pix_valid) begin
        n_checks++;
        if (k >= N) begin
          $display("[TB] FAIL extra_pixel: got valid after %0d beats expected none", k);
        end else begin
          exp_beat = {model_pix[k], XW'(k % W), YW'(k / W), k == 0, (k % W) == W-1, k == N-1};
          got_beat = {pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof};
          if (got_beat !== exp_beat)
            $display("[TB] FAIL pix_beat%0d: {data,x,y,sof,eol,eof} got %h expected %h", k, got_beat, exp_beat);
          else n_pass++;
          if (pix_ready) k++;
        end
      end
      res_valid = (sent < N) && (rand_res ? ($urandom_range(0, 2) != 0) : 1'b1);
      res_data  = rand_res ? RW'($urandom) : RW'(sent);
      addr = AW'($urandom_range(0, N-1));
      mask_rd_addr = addr;
      rd_armed  = mask_known[addr];
      rd_expect = model_mask[addr];
      if (res_valid) begin
        model_mask[sent] = res_data;
        mask_known[sent] = 1'b1;
        sent++;
      end
    end
    n_checks++;
    if (k != N || sent != N) $display("[TB] FAIL frame_timeout: beats/results got %0d/%0d expected %0d", k, sent, N);
    else n_pass++;
    @(negedge clk);
    pix_ready = 1'b0;
    res_valid = 1'b0;
    n_checks++;
    if ({pix_valid, busy} !== 2'b01) $display("[TB] FAIL drain_entry: {valid,busy} got %b expected 01", {pix_valid, busy});
    else n_pass++;
  endtask

  task automatic finish_frame(input bit do_overflow, input bit rep, input logic [XW-1:0] cx, input logic [YW-1:0] cy);
    if (do_overflow) begin
      @(negedge clk);
      n_checks++;
      if (res_overflow !== 1'b0) $display("[TB] FAIL overflow_early: got %b expected 0", res_overflow);
      else n_pass++;
      res_valid = 1'b1;
      res_data  = 8'hEE;
      @(negedge clk);
      res_valid = 1'b0;
      n_checks++;
      if (res_overflow !== 1'b1) $display("[TB] FAIL overflow_set: got %b expected 1", res_overflow);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (frame_done !== 1'b0) $display("[TB] FAIL done_before_cent: got %b expected 0", frame_done);
    else n_pass++;
    repeat_en  = rep;
    cent_valid = 1'b1;
    cent_x     = cx;
    cent_y     = cy;
    @(negedge clk);
    n_checks++;
    if ({frame_done, frame_cent_valid, frame_cent_x, frame_cent_y} !== {2'b11, cx, cy})
      $display("[TB] FAIL done_pulse: {done,cv,cx,cy} got %b expected %b",
               {frame_done, frame_cent_valid, frame_cent_x, frame_cent_y}, {2'b11, cx, cy});
    else n_pass++;
    cent_x = ~cx;
    cent_y = ~cy;
    model_frames++;
    @(negedge clk);
    cent_valid = 1'b0;
    n_checks++;
    if ({frame_done, busy, pix_valid, frame_cent_valid, frame_cent_x, frame_cent_y} !== {1'b0, rep, 1'b0, !rep, cx, cy})
      $display("[TB] FAIL after_done: {done,busy,valid,cv,cx,cy} got %b expected %b",
               {frame_done, busy, pix_valid, frame_cent_valid, frame_cent_x, frame_cent_y},
               {1'b0, rep, 1'b0, !rep, cx, cy});
    else n_pass++;
    n_checks++;
    if (frame_count !== 16'(model_frames)) $display("[TB] FAIL frame_count: got %0d expected %0d", frame_count, model_frames);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (load_ready !== 1'b1) $display("[TB] FAIL idle_load_ready: got %b expected 1", load_ready);
    else n_pass++;
  endtask

  task automatic test_stream();
    load_frame(1'b1);
    do_start();
    run_frame(1'b0, 1'b0);
    finish_frame(1'b1, 1'b0, 2'd2, 2'd1);
    @(negedge clk);
    mask_rd_addr = 4'd5;
    @(negedge clk);
    n_checks++;
    if (mask_rd_data !== 8'd5) $display("[TB] FAIL mask_readback5: got %0d expected 5", mask_rd_data);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    do_start();
    run_frame(1'b1, 1'b1);
    finish_frame(1'b0, 1'b1, XW'($urandom), YW'($urandom));
  endtask

  task automatic test_back_to_back();
    run_frame(1'b1, 1'b1);
    finish_frame(1'b0, 1'b0, XW'($urandom), YW'($urandom));
  endtask

  task automatic test_clear();
    do_start();
    pix_ready = 1'b1;
    repeat (4) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    pix_ready = 1'b0;
    mask_rd_addr = 4'd9;
    n_checks++;
    if ({pix_valid, busy, load_ready} !== 3'b001)
      $display("[TB] FAIL clear_state: {valid,busy,load_ready} got %b expected 001", {pix_valid, busy, load_ready});
    else n_pass++;
    n_checks++;
    if (frame_count !== 16'(model_frames)) $display("[TB] FAIL clear_count_kept: got %0d expected %0d", frame_count, model_frames);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (mask_rd_data !== model_mask[9]) $display("[TB] FAIL clear_mask_kept: got %h expected %h", mask_rd_data, model_mask[9]);
    else n_pass++;
  endtask

  task automatic test_reset_in_drain();
    load_frame(1'b0);
    do_start();
    run_frame(1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_in_drain");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({load_ready, busy} !== 2'b10) $display("[TB] FAIL post_reset_idle: {load_ready,busy} got %b expected 10", {load_ready, busy});
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      model_mask[i] = '0;
      mask_known[i] = 1'b0;
    end
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_reset_in_drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_stream_engine.md
# frame_stream_engine

Synthesizable, parametrised frame source and sink for the face-detection pixel filters: buffers one frame of CHANNELS×DEPTH pixels, replays it in raster order over a valid/ready stream with position and framing tags, captures the filter's per-pixel result stream into a mask buffer, and latches the filter's centroid. It sits between the host/loader and any pixel filter, replacing per-filter ad-hoc feeders, and adds backpressure, frame repeat and mask readback.

## Interface
- IMG_WIDTH, 256, pixels per line (≥2)
- IMG_HEIGHT, 256, lines per frame (≥2)
- DEPTH, 8, bits per channel
- CHANNELS, 3, channels per pixel; channel 0 in LSBs of packed words
- RES_W, 8, bits per result sample
- Derived: N = IMG_WIDTH*IMG_HEIGHT, AW = $clog2(N), XW = $clog2(IMG_WIDTH), YW = $clog2(IMG_HEIGHT)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous abort to IDLE, buffers discarded
- load_valid / load_ready  in / out  1 / 1  loader handshake
- load_data  in  CHANNELS*DEPTH  raster-order pixel
- start  in  1  begin streaming (honoured in LOADED only)
- repeat_en  in  1  sampled at frame end: replay instead of stopping
- pix_valid / pix_ready  out / in  1 / 1  filter-input handshake
- pix_data  out  CHANNELS*DEPTH  pixel
- pix_x, pix_y  out  XW, YW  raster position
- pix_sof, pix_eol, pix_eof  out  1 each  first pixel, last in line, last in frame
- res_valid  in  1  result sample (no backpressure)
- res_data  in  RES_W  result sample
- cent_valid  in  1  centroid strobe from filter
- cent_x, cent_y  in  XW, YW  centroid
- frame_cent_valid, frame_cent_x, frame_cent_y  out  1, XW, YW  latched centroid
- mask_rd_addr  in  AW  mask readback address
- mask_rd_data  out  RES_W  mask readback data, 1-cycle latency
- busy  out  1  state is STREAM or DRAIN
- frame_done  out  1  one-cycle pulse at frame completion
- res_overflow  out  1  sticky: result received beyond N
- frame_count  out  16  completed frames, wraps

## Operation
- States: IDLE, LOADED, STREAM, DRAIN. Reset → IDLE; all outputs 0, counters 0.
- IDLE: load_ready=1; each load_valid&load_ready writes pixel buffer at load counter, counter++. Beat N-1 → LOADED, load_ready=0 next cycle.
- LOADED: start → STREAM; resets pixel index, result counter, frame_cent_valid, res_overflow.
- STREAM: buffer read 1-cycle latency; prefetch register keeps pix_valid continuous under pix_ready=1. pix_data/x/y/flags stable while pix_valid&!pix_ready. x wraps at IMG_WIDTH-1, y increments. Handshake of pix_eof → DRAIN.
- Results: accepted in STREAM and DRAIN only; write mask buffer at result counter, counter++. Counter==N with res_valid → drop, set res_overflow. Results in other states ignored.
- Centroid: first cent_valid in STREAM/DRAIN latched, frame_cent_valid=1; later strobes ignored until next frame start.
- DRAIN: when result counter==N and frame_cent_valid: frame_done pulse, frame_count++, then STREAM if repeat_en else LOADED. Replay reuses pixel buffer, clears result counter and centroid latch.
- clear: any state → IDLE next cycle, pix_valid=0, load counter 0; frame_count, mask contents kept.
- Mask readback valid any state; reading an address being written same cycle returns old data.

## Timing
- start in cycle T → pix_valid=1 with pixel 0, pix_sof=1 at T+2.
- Full throughput: one pixel/cycle with pix_ready=1.
- Last result + centroid present at cycle T → frame_done at T+1; replay pix_valid at T+3.
- pix_valid never drops mid-frame except while refilling after stall release (≤0 bubbles required).

## Structure
- Package frame_stream_pkg: state enum, AW/XW/YW helper functions, flag bundle struct.
- Sub-module frame_ram (single write port, registered read port, DEPTH/width parameters), instantiated twice: pixel buffer and mask buffer.

## Test plan (IMG_WIDTH=4, IMG_HEIGHT=4, CHANNELS=3)
- Load pixels 0..15 (data=i·0x010101) → LOADED after 16th beat, load_ready=0.
- start, pix_ready=1 → 16 consecutive beats, pix_x/pix_y raster, sof at 0, eol at x=3, eof at 15.
- pix_ready toggled random → every pixel exactly once, data held across stalls.
- 16 results res_data=i, centroid (2,1) → frame_done once, frame_count=1, mask_rd_addr=5 → 5 next cycle; 17th result → res_overflow=1.
- repeat_en=1 → second identical frame, frame_count=2; clear mid-STREAM → IDLE, pix_valid=0 next cycle.
- rst_n low mid-DRAIN → all outputs 0 immediately, state IDLE.
